// File: rtl/muldiv_pkg.sv
// Shared pipeline definitions for the multi-cycle multiply/divide unit:
// FSM state encoding and the isdiv operation encoding.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv.sv
// Iterative signed MULT/DIV: magnitudes are processed one radix-2 step per
// cycle on a single shared adder/subtractor, then sign-corrected into HI/LO.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isdiv,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0]   ONE  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE2 = (2*WIDTH)'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             isdiv_q, isdiv_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] a_q, a_d;      // MULT: product high half, DIV: partial remainder
    logic [WIDTH-1:0] b_q, b_d;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0] p_q, p_d;      // MULT: multiplier/product low, DIV: dividend/quotient
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b, rem_sh, add_a, add_b;
    logic [WIDTH:0]     sum, mul_sel;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign mag_a = srca[WIDTH-1] ? (~srca + ONE) : srca;
    assign mag_b = srcb[WIDTH-1] ? (~srcb + ONE) : srcb;

    // Single adder: add for MULT, trial subtract for DIV (carry-out = no borrow).
    assign rem_sh  = {a_q[WIDTH-2:0], p_q[WIDTH-1]};
    assign add_a   = isdiv_q ? rem_sh : a_q;
    assign add_b   = isdiv_q ? ~b_q : b_q;
    assign sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, isdiv_q};
    assign mul_sel = p_q[0] ? sum : {1'b0, a_q};

    assign prod     = {a_q, p_q};
    assign prod_neg = ~prod + ONE2;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        isdiv_d = isdiv_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    isdiv_d = isdiv;
                    a_d     = '0;
                    b_d     = mag_b;
                    p_d     = mag_a;
                    if (isdiv == OP_DIV) begin
                        // Divide-by-zero leaves the raw all-ones quotient alone.
                        negq_d = (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (srcb != '0);
                        negr_d = srca[WIDTH-1];
                    end else begin
                        negq_d = srca[WIDTH-1] ^ srcb[WIDTH-1];
                        negr_d = 1'b0;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (isdiv_q == OP_DIV) begin
                    if (sum[WIDTH]) begin
                        a_d = sum[WIDTH-1:0];
                        p_d = {p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        a_d = rem_sh;
                        p_d = {p_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    a_d = mul_sel[WIDTH:1];
                    p_d = {mul_sel[0], p_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (isdiv_q == OP_MULT) begin
                    {hi_d, lo_d} = negq_q ? prod_neg : prod;
                end else begin
                    lo_d = negq_q ? (~p_q + ONE) : p_q;
                    hi_d = negr_q ? (~a_q + ONE) : a_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            isdiv_q <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            isdiv_q <= isdiv_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
